// File: rtl/store_pkg.sv
// Shared definitions for the STORE-mode matrix receiver.
//   MAX_DIM       largest accepted row/column count
//   MATRIX_WIDTH  width of the packed 5x5 byte matrix word
//   CH_*          ASCII byte values recognised by the tokeniser
//   err_code_e    error codes reported on err_code
//   store_state_e receiver FSM states
package store_pkg;

  localparam int MAX_DIM      = 5;
  localparam int MATRIX_WIDTH = 200;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;

  // Accumulator ceiling: any number above 255 is reported as 256.
  localparam logic [8:0] ACC_SAT = 9'd256;

  typedef enum logic [1:0] {
    ERR_TIMEOUT = 2'd0,
    ERR_DIM     = 2'd1,
    ERR_RANGE   = 2'd2,
    ERR_BADCHAR = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_M,
    S_GET_N,
    S_GET_ELEM,
    S_COMMIT
  } store_state_e;

  function automatic logic dim_ok(input logic [8:0] v);
    return (v >= 9'd1) && (v <= 9'(MAX_DIM));
  endfunction

endpackage

// File: rtl/dec_token_parser.sv
// ASCII decimal tokeniser.
//   clk, rst_n   clock, async active-low reset
//   byte_valid   rx_data is a byte to be consumed this cycle
//   rx_data      received byte
//   clear        drop any partially accumulated number
//   tok_valid    a separator just terminated a number (combinational)
//   tok_val      value of that number, saturated at 256
//   bad_char     byte is neither digit nor separator (combinational)
//   pending      at least one digit of an unterminated number is held
module dec_token_parser
  import store_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] rx_data,
  input  logic       clear,
  output logic       tok_valid,
  output logic [8:0] tok_val,
  output logic       bad_char,
  output logic       pending
);

  logic [8:0]  acc;
  logic        seen;
  logic        is_digit;
  logic        is_sep;
  logic [11:0] acc_mul;
  logic [8:0]  acc_next;

  always_comb begin
    is_digit  = (rx_data >= CH_0) && (rx_data <= CH_9);
    is_sep    = rx_data inside {CH_SPACE, CH_COMMA, CH_CR, CH_LF};
    // 256*10+9 still fits in 12 bits, so saturation is a single compare.
    acc_mul   = ({3'b000, acc} * 12'd10) + {8'h00, rx_data[3:0]};
    acc_next  = (acc_mul > {3'b000, ACC_SAT}) ? ACC_SAT : acc_mul[8:0];
    tok_valid = byte_valid && is_sep && seen;
    tok_val   = acc;
    bad_char  = byte_valid && !is_digit && !is_sep;
    pending   = seen;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      seen <= 1'b0;
    end else if (clear || (byte_valid && !is_digit)) begin
      acc  <= '0;
      seen <= 1'b0;
    end else if (byte_valid) begin
      acc  <= acc_next;
      seen <= 1'b1;
    end
  end

endmodule

// File: rtl/matrix_store_rx.sv
// STORE-mode matrix receiver: turns "m n e0 .. e(m*n-1)" ASCII input into
// one packed matrix write, or an error pulse with a code.
//   clk, rst_n       clock, async active-low reset
//   enable           STORE mode active
//   rx_data, rx_done received byte and its single-cycle strobe
//   wr_en            single-cycle matrix write strobe
//   wr_dim_x/y       rows/columns of the last committed matrix
//   wr_data          packed elements, element k at [8k +: 8]
//   done_pulse       coincident with wr_en
//   err_pulse        single-cycle error strobe
//   err_code         code of the most recent error
//   busy             a matrix is partially entered
//
// state      | meaning
// -----------+----------------------------------------------
// S_IDLE     | not in STORE mode, outputs quiet
// S_GET_M    | waiting for row count token
// S_GET_N    | waiting for column count token
// S_GET_ELEM | collecting elements into slot k
// S_COMMIT   | one-cycle write of the assembled matrix
module matrix_store_rx
  import store_pkg::*;
#(
  parameter int unsigned ELEM_MAX       = 9,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [7:0]              rx_data,
  input  logic                    rx_done,
  output logic                    wr_en,
  output logic [7:0]              wr_dim_x,
  output logic [7:0]              wr_dim_y,
  output logic [MATRIX_WIDTH-1:0] wr_data,
  output logic                    done_pulse,
  output logic                    err_pulse,
  output logic [1:0]              err_code,
  output logic                    busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Loaded on the byte cycle; reaching zero TIMEOUT_CYCLES-1 cycles later
  // puts the error pulse TIMEOUT_CYCLES+1 cycles after the last byte.
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  store_state_e state, state_next;
  err_code_e    err_code_q, err_sel;

  logic [2:0]              m, n;
  logic [4:0]              k, mn;
  logic [MATRIX_WIDTH-1:0] data;
  logic [TW-1:0]           tmr;

  logic       byte_valid, tok_clear;
  logic       tok_valid, bad_char, tok_pending;
  logic [8:0] tok_val;
  logic       err_set, latch_m, latch_n, store_elem, elem_last, tmr_expired;

  dec_token_parser u_parser (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_valid(byte_valid),
    .rx_data   (rx_data),
    .clear     (tok_clear),
    .tok_valid (tok_valid),
    .tok_val   (tok_val),
    .bad_char  (bad_char),
    .pending   (tok_pending)
  );

  always_comb begin
    mn          = {2'b00, m} * {2'b00, n};
    elem_last   = (k == (mn - 5'd1));
    byte_valid  = rx_done && enable && (state inside {S_GET_M, S_GET_N, S_GET_ELEM});
    busy        = (state inside {S_GET_N, S_GET_ELEM, S_COMMIT}) ||
                  ((state == S_GET_M) && tok_pending);
    tmr_expired = busy && (tmr == '0) && !rx_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    err_sel    = err_code_q;
    latch_m    = 1'b0;
    latch_n    = 1'b0;
    store_elem = 1'b0;
    tok_clear  = 1'b0;
    if (!enable) begin
      state_next = S_IDLE;
      tok_clear  = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          state_next = S_GET_M;
          tok_clear  = 1'b1;
        end
        S_GET_M, S_GET_N, S_GET_ELEM: begin
          if (bad_char) begin
            err_set = 1'b1;
            err_sel = ERR_BADCHAR;
          end else if (tok_valid) begin
            if (state == S_GET_ELEM) begin
              if (tok_val <= 9'(ELEM_MAX)) begin
                store_elem = 1'b1;
                if (elem_last) state_next = S_COMMIT;
              end else begin
                err_set = 1'b1;
                err_sel = ERR_RANGE;
              end
            end else if (dim_ok(tok_val)) begin
              if (state == S_GET_M) begin
                latch_m    = 1'b1;
                state_next = S_GET_N;
              end else begin
                latch_n    = 1'b1;
                state_next = S_GET_ELEM;
              end
            end else begin
              err_set = 1'b1;
              err_sel = ERR_DIM;
            end
          end else if (tmr_expired) begin
            err_set = 1'b1;
            err_sel = ERR_TIMEOUT;
          end
          if (err_set) begin
            state_next = S_GET_M;
            tok_clear  = 1'b1;
          end
        end
        S_COMMIT: state_next = S_GET_M;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m          <= '0;
      n          <= '0;
      k          <= '0;
      data       <= '0;
      wr_dim_x   <= 8'd1;
      wr_dim_y   <= 8'd1;
      err_pulse  <= 1'b0;
      err_code_q <= ERR_TIMEOUT;
      tmr        <= TMR_LOAD;
    end else begin
      err_pulse <= err_set;
      if (err_set) err_code_q <= err_sel;

      if (err_set || !enable) begin
        m    <= '0;
        n    <= '0;
        k    <= '0;
        data <= '0;
      end else begin
        if (latch_m) m <= tok_val[2:0];
        if (latch_n) begin
          n    <= tok_val[2:0];
          k    <= '0;
          data <= '0;
        end
        if (store_elem) begin
          data[{k, 3'b000} +: 8] <= tok_val[7:0];
          k <= k + 5'd1;
          if (elem_last) begin
            wr_dim_x <= {5'b00000, m};
            wr_dim_y <= {5'b00000, n};
          end
        end
      end

      if (rx_done || !busy)  tmr <= TMR_LOAD;
      else if (tmr != '0)    tmr <= tmr - 1'b1;
    end
  end

  assign wr_en      = (state == S_COMMIT);
  assign done_pulse = (state == S_COMMIT);
  assign wr_data    = data;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_matrix_store_rx.sv
// Self-checking bench for matrix_store_rx: directed scenarios plus random
// matrix streams, compared against a token-list reference model.
module tb_matrix_store_rx;

  localparam int EMAX = 9;
  localparam int TO   = 1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [7:0]   rx_data;
  logic         rx_done;
  logic         wr_en;
  logic [7:0]   wr_dim_x;
  logic [7:0]   wr_dim_y;
  logic [199:0] wr_data;
  logic         done_pulse;
  logic         err_pulse;
  logic [1:0]   err_code;
  logic         busy;

  matrix_store_rx #(.ELEM_MAX(EMAX), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .wr_en     (wr_en),
    .wr_dim_x  (wr_dim_x),
    .wr_dim_y  (wr_dim_y),
    .wr_data   (wr_data),
    .done_pulse(done_pulse),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // DUT-side event monitor
  int           dut_wr_cnt = 0;
  int           dut_err_cnt = 0;
  logic [199:0] last_data = '0;
  always @(negedge clk) begin
    if (wr_en) begin
      dut_wr_cnt++;
      last_data = wr_data;
    end
    if (err_pulse) dut_err_cnt++;
  end

  // Reference model: numbers are collected into a token list; the list is
  // interpreted as m, n, elements and judged once a token completes.
  int           m_acc = 0;
  bit           m_seen = 1'b0;
  int           m_vals[$];
  int           mdl_wr_cnt = 0;
  int           mdl_err_cnt = 0;
  int           mdl_m, mdl_n;
  logic [199:0] mdl_data;
  int           t_last = 0;

  logic [7:0] seps[4] = '{8'h20, 8'h2C, 8'h0D, 8'h0A};
  logic [7:0] bads[4] = '{8'h78, 8'h41, 8'h2D, 8'h2E};

  task automatic model_clear();
    m_acc  = 0;
    m_seen = 1'b0;
    m_vals.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, output bit ev_wr, output bit ev_err, output int code);
    int tok;
    ev_wr  = 1'b0;
    ev_err = 1'b0;
    code   = 0;
    if (b >= 8'h30 && b <= 8'h39) begin
      m_acc = m_acc * 10 + int'(b - 8'h30);
      if (m_acc > 256) m_acc = 256;
      m_seen = 1'b1;
    end else if (b == 8'h20 || b == 8'h2C || b == 8'h0D || b == 8'h0A) begin
      if (m_seen) begin
        tok    = m_acc;
        m_acc  = 0;
        m_seen = 1'b0;
        if (m_vals.size() < 2) begin
          if (tok < 1 || tok > 5) begin ev_err = 1'b1; code = 1; end
          else m_vals.push_back(tok);
        end else if (tok > EMAX) begin
          ev_err = 1'b1;
          code   = 2;
        end else begin
          m_vals.push_back(tok);
          if (m_vals.size() == 2 + m_vals[0] * m_vals[1]) begin
            ev_wr    = 1'b1;
            mdl_m    = m_vals[0];
            mdl_n    = m_vals[1];
            mdl_data = '0;
            for (int e = 0; e < mdl_m * mdl_n; e++) mdl_data[8*e +: 8] = 8'(m_vals[2+e]);
            m_vals.delete();
            mdl_wr_cnt++;
          end
        end
      end
    end else begin
      ev_err = 1'b1;
      code   = 3;
    end
    if (ev_err) begin
      model_clear();
      mdl_err_cnt++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ew, ee;
    int code;
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    t_last  = cyc;
    @(negedge clk);
    rx_done = 1'b0;
    model_byte(b, ew, ee, code);
    chk("err_pulse", 200'(err_pulse), 200'(ee));
    chk("wr_en", 200'(wr_en), 200'(ew));
    chk("done_pulse", 200'(done_pulse), 200'(ew));
    if (ee) chk("err_code", 200'(err_code), 200'(code));
    if (ew) begin
      chk("dim_x", 200'(wr_dim_x), 200'(mdl_m));
      chk("dim_y", 200'(wr_dim_y), 200'(mdl_n));
      chk("wr_data", wr_data, mdl_data);
    end
    @(negedge clk);
    chk("wr_en_t2", 200'(wr_en), 200'(0));
    chk("err_pulse_t2", 200'(err_pulse), 200'(0));
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_wr_en"}, 200'(wr_en), 200'(0));
    chk({pfx, "_done"}, 200'(done_pulse), 200'(0));
    chk({pfx, "_err_pulse"}, 200'(err_pulse), 200'(0));
    chk({pfx, "_err_code"}, 200'(err_code), 200'(0));
    chk({pfx, "_busy"}, 200'(busy), 200'(0));
    chk({pfx, "_dim_x"}, 200'(wr_dim_x), 200'(1));
    chk({pfx, "_dim_y"}, 200'(wr_dim_y), 200'(1));
    chk({pfx, "_data"}, wr_data, 200'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, t0, mm, nn, kind, pos;
    bit found;
    int toks[$];

    rst_n   = 1'b0;
    enable  = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    model_clear();

    // normal 2x2
    send_str("2 2 1 2 3 4\n");
    chk("2x2_low", 200'(last_data[31:0]), 200'(32'h04030201));
    chk("2x2_high", 200'(last_data[199:32]), 200'(0));
    chk("2x2_dims", 200'({wr_dim_x, wr_dim_y}), 200'(16'h0202));

    // bad dimension, then a 1x1
    send_str("6 ");
    chk("dim_code", 200'(err_code), 200'(1));
    send_str("1 1 5\n");
    chk("1x1_val", 200'(last_data[7:0]), 200'(5));
    chk("1x1_dims", 200'({wr_dim_x, wr_dim_y}), 200'(16'h0101));

    // range, including saturation
    send_str("1 1 12 ");
    chk("range_code", 200'(err_code), 200'(2));
    send_str("1 1 999 ");
    chk("sat_code", 200'(err_code), 200'(2));
    chk("err_count_a", 200'(dut_err_cnt), 200'(3));

    // bad character, collapsed separators
    send_str("2 x");
    chk("badchar_code", 200'(err_code), 200'(3));
    send_str("2,,3\r\n1 2 3 4 5 6 ");
    chk("collapse_dims", 200'({wr_dim_x, wr_dim_y}), 200'(16'h0203));

    // timeout
    send_str("3 3 1 2 ");
    t0    = t_last;
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      @(negedge clk);
      if (err_pulse) found = 1'b1;
    end
    chk("to_seen", 200'(found), 200'(1));
    chk("to_latency", 200'(cyc - t0), 200'(TO + 1));
    chk("to_code", 200'(err_code), 200'(0));
    chk("to_busy", 200'(busy), 200'(0));
    model_clear();
    mdl_err_cnt++;

    // enable drop mid-matrix
    send_str("2 2 1 ");
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_busy", 200'(busy), 200'(0));
    chk("drop_err", 200'(err_pulse), 200'(0));
    model_clear();
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    w0 = dut_wr_cnt;
    send_str("1 1 7\n");
    chk("reen_writes", 200'(dut_wr_cnt - w0), 200'(1));
    chk("reen_val", 200'(last_data[7:0]), 200'(7));

    // random matrix streams with occasional corruption
    for (int r = 0; r < 40; r++) begin
      toks.delete();
      mm = $urandom_range(1, 5);
      nn = $urandom_range(1, 5);
      toks.push_back(mm);
      toks.push_back(nn);
      for (int e = 0; e < mm * nn; e++) toks.push_back($urandom_range(0, 9));
      kind = $urandom_range(0, 7);
      pos  = $urandom_range(0, toks.size() - 1);
      if (kind == 0) toks[pos] = $urandom_range(10, 999);
      if (kind == 1 && pos < 2) toks[pos] = 0;
      for (int i = 0; i < toks.size(); i++) begin
        if (kind == 2 && i == pos) send_byte(bads[$urandom_range(0, 3)]);
        send_str($sformatf("%0d", toks[i]));
        repeat ($urandom_range(1, 2)) send_byte(seps[$urandom_range(0, 3)]);
      end
    end
    chk("rand_wr_cnt", 200'(dut_wr_cnt), 200'(mdl_wr_cnt));
    chk("rand_err_cnt", 200'(dut_err_cnt), 200'(mdl_err_cnt));

    // reset mid-matrix
    send_str("3 3 1 ");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("arst");
    repeat (2) @(negedge clk);
    check_reset_vals("arst_hold");
    rst_n = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    w0 = dut_wr_cnt;
    send_str("1 1 3\n");
    chk("post_rst_writes", 200'(dut_wr_cnt - w0), 200'(1));
    chk("post_rst_val", 200'(last_data[7:0]), 200'(3));

    chk("final_wr_cnt", 200'(dut_wr_cnt), 200'(mdl_wr_cnt));
    chk("final_err_cnt", 200'(dut_err_cnt), 200'(mdl_err_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
